// File: rtl/wb_queue.sv
// Register-file write-back queue: buffers ALU and load results in a circular FIFO
// and drains them in acceptance order, one write per cycle, unless held.
module wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid_i,
  input  logic [4:0]                   alu_rd_i,
  input  logic [DATA_WIDTH-1:0]        alu_data_i,
  output logic                         alu_ready_o,
  input  logic                         ld_valid_i,
  input  logic [4:0]                   ld_rd_i,
  input  logic [DATA_WIDTH-1:0]        ld_data_i,
  output logic                         ld_ready_o,
  input  logic                         hold_i,
  output logic                         WE3,
  output logic [4:0]                   A3,
  output logic [DATA_WIDTH-1:0]        WD3,
  input  logic [4:0]                   q1_i,
  input  logic [4:0]                   q2_i,
  output logic                         pend1_o,
  output logic                         pend2_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]            rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;

  logic                  full, empty;
  logic                  alu_acc, ld_acc, push, pop;
  logic [4:0]            push_rd;
  logic [DATA_WIDTH-1:0] push_data;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign alu_ready_o = !full;
  assign ld_ready_o  = !full && !alu_valid_i;
  assign alu_acc     = alu_valid_i && alu_ready_o;
  assign ld_acc      = ld_valid_i && ld_ready_o;

  // Writes to x0 complete the handshake but are discarded.
  assign push = (alu_acc && (alu_rd_i != 5'd0)) || (ld_acc && (ld_rd_i != 5'd0));
  assign pop  = !empty && !hold_i;

  always_comb begin
    push_rd   = ld_rd_i;
    push_data = ld_data_i;
    if (alu_acc) begin
      push_rd   = alu_rd_i;
      push_data = alu_data_i;
    end
  end

  assign WE3     = pop;
  assign A3      = empty ? 5'd0 : rd_mem[head];
  assign WD3     = empty ? '0   : data_mem[head];
  assign count_o = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy is defined solely by head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= push_rd;
      data_mem[tail] <= push_data;
    end
  end

  // An entry i is occupied when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] off;
    pend1_o = 1'b0;
    pend2_o = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count) begin
        if (rd_mem[i] == q1_i) pend1_o = 1'b1;
        if (rd_mem[i] == q2_i) pend2_o = 1'b1;
      end
    end
    if (q1_i == 5'd0) pend1_o = 1'b0;
    if (q2_i == 5'd0) pend2_o = 1'b0;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register data width.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two, >=2), giving the number of buffered write entries.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports alu_valid_i (input, 1), alu_rd_i (input, 5) and alu_data_i (input, DATA_WIDTH), the ALU-result write request.
REQ-006 The block SHALL have port alu_ready_o, output, 1, asserted when an ALU request is accepted this cycle.
REQ-007 The block SHALL have ports ld_valid_i (input, 1), ld_rd_i (input, 5) and ld_data_i (input, DATA_WIDTH), the load-result write request.
REQ-008 The block SHALL have port ld_ready_o, output, 1, asserted when a load request is accepted this cycle.
REQ-009 The block SHALL have port hold_i, input, 1, which freezes draining when high.
REQ-010 The block SHALL have ports WE3 (output, 1), A3 (output, 5) and WD3 (output, DATA_WIDTH), the register-file write port.
REQ-011 The block SHALL have ports q1_i and q2_i, inputs, 5 each, the decode-stage source register numbers to check.
REQ-012 The block SHALL have ports pend1_o and pend2_o, outputs, 1 each, set when q1_i or q2_i respectively has a queued write.
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH)+1, the current number of occupied entries.

Function
REQ-014 Storage SHALL be a circular FIFO of DEPTH entries {rd, data}, with head and tail pointers and an occupancy counter.
REQ-015 Acceptance: a request is accepted when valid && ready at the rising edge; ALU has fixed priority over load.
REQ-016 alu_ready_o SHALL equal !full, where full means count == DEPTH.
REQ-017 ld_ready_o SHALL equal !full && !alu_valid_i.
REQ-018 A request with rd == 0 SHALL handshake normally but SHALL NOT be enqueued or change count.
REQ-019 Full with a simultaneous pop: ready SHALL stay low; full is evaluated on the registered count, with no same-cycle slot reuse.
REQ-020 Drain: WE3 SHALL equal (count != 0) && !hold_i, with A3 and WD3 driven from the head entry.
REQ-021 When WE3 = 1, head SHALL advance at the rising edge; the register file captures the write on the preceding falling edge.
REQ-022 When count == 0, A3 and WD3 SHALL be driven to 0.
REQ-023 Latency: a request accepted at edge N into an empty queue SHALL appear on WE3/A3/WD3 during cycle N+1.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged.
REQ-025 Order: writes SHALL leave the queue in acceptance order, so a later write to the same rd overwrites an earlier one in the register file.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 count_o SHALL never exceed DEPTH or underflow below 0.
REQ-028 Pending flags: pend1_o = 1 iff q1_i != 0 and any occupied entry has rd == q1_i; pend2_o follows the same rule for q2_i.
REQ-029 pend1_o and pend2_o SHALL be combinational over the registered entries and SHALL exclude the entry being accepted this cycle.
REQ-030 While hold_i = 1, requests SHALL still be accepted until full, and no entry SHALL be dropped.

Reset
REQ-031 While rst = 1, head, tail and count SHALL clear to 0 immediately, independent of clk.
REQ-032 While rst = 1, WE3, A3, WD3, pend1_o, pend2_o and count_o SHALL be 0, and alu_ready_o SHALL be 1.
REQ-033 A reset mid-operation SHALL discard all queued writes, with no partial write issued after rst rises.
REQ-034 Entry data contents SHALL not be required to reset.

Verification
REQ-035 The bench SHALL cover: reset, then ALU rd=5, data=0x1234 for one cycle -> next cycle WE3=1, A3=5, WD3=0x1234, count_o=1; the following cycle count_o=0 and WE3=0.
REQ-036 The bench SHALL cover: ALU and load both valid in the same cycle (rd 3 and rd 4) -> alu_ready_o=1, ld_ready_o=0; the load is accepted next cycle, and WE3 shows rd 3 then rd 4.
REQ-037 The bench SHALL cover: hold_i=1 with 4 ALU pushes of rd 1..4 -> count_o=4, both ready outputs 0; q1_i=3 gives pend1_o=1, q2_i=7 gives pend2_o=0; after hold_i drops, WE3 shows rd 1,2,3,4 over 4 consecutive cycles.
REQ-038 The bench SHALL cover: ALU rd=0, data=0xFFFF -> handshake completes, count_o stays 0, WE3 stays 0, and q1_i=0 gives pend1_o=0.
REQ-039 The bench SHALL cover: 3 entries queued, then rst pulsed between clock edges -> count_o=0 and WE3=0 immediately, with no write issued afterwards.
REQ-040 The bench SHALL cover: 10 pushes of rd=k, data=k with hold_i toggling randomly -> exactly 10 writes issued in order and pointers wrap correctly.
